// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: PC, req/ack fetch FSM, stall skid and redirect squash.
// Optional `IF_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module if_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [PC_W-1:0]    branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc_plus1,
  output logic [3:0]         opcode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcp1_q, pcp1_d;
  logic               squash_q, squash_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               load_en;
  logic [INSTR_W-1:0] load_data;
  logic [PC_W-1:0]    pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ISSUE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pcp1_q   <= '0;
      squash_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pcp1_q   <= pcp1_d;
      squash_q <= squash_d;
      skid_q   <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_ack) begin
          state_d = (squash_q || pc_src || !stall) ? ST_ISSUE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (pc_src || !stall) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcp1_d    = pcp1_q;
    squash_d  = squash_q;
    skid_d    = skid_q;
    load_en   = 1'b0;
    load_data = skid_q;
    case (state_q)
      ST_ISSUE: begin
        req_d  = 1'b1;
        addr_d = pc_src ? branch_target : pc_q;
      end
      ST_WAIT: begin
        if (imem_ack) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          // A squashed or same-cycle-redirected response is simply dropped.
          if (!squash_q && !pc_src) begin
            if (stall) begin
              skid_d = imem_rdata;
            end else begin
              load_en   = 1'b1;
              load_data = imem_rdata;
            end
          end
        end else if (pc_src) begin
          squash_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (pc_src) begin
          skid_d = '0;
        end else if (!stall) begin
          load_en = 1'b1;
        end
      end
      default: ;
    endcase
    if (load_en) begin
      valid_d = 1'b1;
      instr_d = load_data;
      pcp1_d  = pc_inc;
      pc_d    = pc_inc;
    end
    if (pc_src) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    if_valid    = valid_q;
    if_instr    = instr_q;
    if_pc_plus1 = pcp1_q;
    opcode      = instr_q[INSTR_W-1 -: 4];
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_en && !pc_src) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && valid_q) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
